// File: rtl/hdbn_plug_b_param.sv
// HDB-N B-insertion stage: rewrites the first zero of an N+1 zero run as B when a V follows even mark parity.
// Latency N+2 accepted symbols; stalls in place while i_valid is low (no ready, source-paced).
module hdbn_plug_b_param #(
  parameter int N     = 3,
  parameter bit P_INIT = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [1:0]       i_code,
  input  logic             i_b_en,
  output logic             o_valid,
  output logic [1:0]       o_code,
  output logic             o_err,
  output logic [CNT_W-1:0] o_b_cnt
);

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_MARK = 2'b01;
  localparam logic [1:0] C_V    = 2'b10;
  localparam logic [1:0] C_B    = 2'b11;

  typedef struct packed {
    logic [1:0] code;
    logic       vld;
  } stage_t;

  stage_t s_q [N+2];
  logic   par_q;
  logic   adv_q;

  logic illegal;
  logic chk;
  logic run_ok;
  logic ins;
  logic malformed;

  // A B needs the whole N-deep window ahead of the V to be accepted zeros.
  always_comb begin
    run_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (!(s_q[k].vld && (s_q[k].code == C_ZERO))) run_ok = 1'b0;
    end
  end

  assign illegal   = (i_code == C_B);
  assign chk       = (i_code == C_V) && !par_q && i_b_en;
  assign ins       = chk && s_q[N-1].vld && (s_q[N-1].code == C_ZERO);
  assign malformed = chk && !run_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N + 2; k++) s_q[k] <= '0;
      par_q   <= P_INIT;
      adv_q   <= 1'b0;
      o_err   <= 1'b0;
      o_b_cnt <= '0;
    end else begin
      adv_q <= i_valid;
      o_err <= 1'b0;
      if (i_valid) begin
        s_q[0] <= '{code: (illegal ? C_ZERO : i_code), vld: 1'b1};
        for (int k = 1; k < N + 2; k++) s_q[k] <= s_q[k-1];
        if (ins) begin
          s_q[N]  <= '{code: C_B, vld: 1'b1};
          o_b_cnt <= o_b_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (i_code == C_V)         par_q <= 1'b0;
        else if (i_code == C_MARK) par_q <= ~par_q;
        o_err <= illegal || malformed;
      end
    end
  end

  // Gating with adv_q makes each stored symbol appear for exactly one beat.
  assign o_valid = s_q[N+1].vld && adv_q;
  assign o_code  = s_q[N+1].code;

endmodule

// File: tb/tb_hdbn_plug_b_param.sv
// Directed bench for hdbn_plug_b_param at N=3 (main), N=2 and N=5.
module tb_hdbn_plug_b_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_en = 1'b1;
  logic v2 = 1'b0, v3 = 1'b0, v5 = 1'b0;
  logic [1:0] c2 = 2'b00, c3 = 2'b00, c5 = 2'b00;
  logic ov2, ov3, ov5, oe2, oe3, oe5;
  logic [1:0] oc2, oc3, oc5;
  logic [15:0] cnt2, cnt3, cnt5;

  int mon_sel = 3;
  int errc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] outq[$];
  logic [1:0] stim[$];
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  hdbn_plug_b_param #(.N(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(v3), .i_code(c3), .i_b_en(b_en),
    .o_valid(ov3), .o_code(oc3), .o_err(oe3), .o_b_cnt(cnt3));
  hdbn_plug_b_param #(.N(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .i_code(c2), .i_b_en(b_en),
    .o_valid(ov2), .o_code(oc2), .o_err(oe2), .o_b_cnt(cnt2));
  hdbn_plug_b_param #(.N(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_valid(v5), .i_code(c5), .i_b_en(b_en),
    .o_valid(ov5), .o_code(oc5), .o_err(oe5), .o_b_cnt(cnt5));

  always @(negedge clk) begin
    case (mon_sel)
      2: begin if (ov2) outq.push_back(oc2); if (oe2) errc++; end
      5: begin if (ov5) outq.push_back(oc5); if (oe5) errc++; end
      default: begin if (ov3) outq.push_back(oc3); if (oe3) errc++; end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic [1:0] code);
    case (which)
      2: begin v2 = 1'b1; c2 = code; end
      5: begin v5 = 1'b1; c5 = code; end
      default: begin v3 = 1'b1; c3 = code; end
    endcase
    @(posedge clk);
    #1;
    v2 = 1'b0; v3 = 1'b0; v5 = 1'b0;
    c2 = 2'b00; c3 = 2'b00; c5 = 2'b00;
  endtask

  // which equals the DUT's N; N+2 trailing zeros push every real symbol out.
  task automatic run(input int which, input int gap);
    for (int i = 0; i < stim.size(); i++) begin
      drive(which, stim[i]);
      repeat (gap) idle();
    end
    for (int i = 0; i < which + 2; i++) drive(which, 2'b00);
    idle();
    idle();
  endtask

  task automatic do_reset(input int sel);
    v2 = 1'b0; v3 = 1'b0; v5 = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    mon_sel = sel;
    idle();
    outq.delete();
    errc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ov3); end
    n_chk++; if (oc3 !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %b expected 00", oc3); end
    n_chk++; if (oe3 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", oe3); end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt3); end
    n_chk++; if ((ov2 | ov5) !== 1'b0) begin n_fail++; $display("FAIL reset_valid_n25: got %b%b expected 00", ov2, ov5); end
  endtask

  task automatic test_no_b_latency();
    do_reset(3);
    b_en = 1'b1;
    stim = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 5; i++) begin
      drive(3, stim[i]);
      n_chk++;
      if (ov3 !== (i == 4)) begin
        n_fail++; $display("FAIL latency_cycle%0d: got o_valid %b expected %b", i + 1, ov3, (i == 4));
      end
    end
    for (int i = 0; i < 5; i++) drive(3, 2'b00);
    idle(); idle();
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL nob_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL nob_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL nob_cnt: got %0d expected 0", cnt3); end
    n_chk++; if (errc != 0) begin n_fail++; $display("FAIL nob_err: got %0d expected 0", errc); end
  endtask

  task automatic test_b_insert(input int gap);
    do_reset(3);
    stim = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
    run(3, gap);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b_insert_gap%0d_count: got %0d expected %0d", gap, outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL b_insert_gap%0d_sym%0d: got %b expected %b", gap, i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt3 !== 16'd1) begin n_fail++; $display("FAIL b_insert_gap%0d_cnt: got %0d expected 1", gap, cnt3); end
    n_chk++; if (errc != 0) begin n_fail++; $display("FAIL b_insert_gap%0d_err: got %0d expected 0", gap, errc); end
  endtask

  task automatic test_back_to_back();
    do_reset(3);
    stim = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
    run(3, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt3 !== 16'd1) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 1", cnt3); end
  endtask

  task automatic test_bypass();
    do_reset(3);
    b_en = 1'b0;
    stim = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    run(3, 0);
    b_en = 1'b1;
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bypass_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL bypass_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL bypass_cnt: got %0d expected 0", cnt3); end
    n_chk++; if (errc != 0) begin n_fail++; $display("FAIL bypass_err: got %0d expected 0", errc); end
  endtask

  task automatic test_illegal();
    do_reset(3);
    stim = '{2'b01, 2'b11, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    run(3, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL illegal_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL illegal_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (errc != 1) begin n_fail++; $display("FAIL illegal_err: got %0d pulses expected 1", errc); end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL illegal_cnt: got %0d expected 0", cnt3); end
  endtask

  task automatic test_malformed();
    do_reset(3);
    stim = '{2'b01, 2'b01, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
    run(3, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL malformed_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL malformed_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (errc != 1) begin n_fail++; $display("FAIL malformed_err: got %0d pulses expected 1", errc); end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL malformed_cnt: got %0d expected 0", cnt3); end
    do_reset(3);
    stim = '{2'b10};
    run(3, 0);
    n_chk++; if (errc != 1) begin n_fail++; $display("FAIL early_v_err: got %0d pulses expected 1", errc); end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL early_v_cnt: got %0d expected 0", cnt3); end
  endtask

  task automatic test_reset_midstream();
    do_reset(3);
    drive(3, 2'b01);
    drive(3, 2'b01);
    drive(3, 2'b00);
    rst = 1'b1;
    #1;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", ov3); end
    n_chk++; if (oc3 !== 2'b00) begin n_fail++; $display("FAIL midrst_code: got %b expected 00", oc3); end
    n_chk++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", cnt3); end
    n_chk++; if (outq.size() != 0) begin n_fail++; $display("FAIL midrst_out: got %0d symbols expected 0", outq.size()); end
    idle();
    rst = 1'b0;
    idle();
    outq.delete();
    errc = 0;
    stim = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    run(3, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL restart_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (errc != 0) begin n_fail++; $display("FAIL restart_err: got %0d expected 0", errc); end
  endtask

  task automatic test_param_n();
    do_reset(2);
    stim = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
    run(2, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL n2_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL n2_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt2 !== 16'd1) begin n_fail++; $display("FAIL n2_cnt: got %0d expected 1", cnt2); end
    do_reset(5);
    stim = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    exp_q = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    run(5, 0);
    n_chk++;
    if (outq.size() != exp_q.size()) begin
      n_fail++; $display("FAIL n5_count: got %0d expected %0d", outq.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (outq[i] !== exp_q[i]) begin n_fail++; $display("FAIL n5_sym%0d: got %b expected %b", i, outq[i], exp_q[i]); end
    end
    n_chk++; if (cnt5 !== 16'd1) begin n_fail++; $display("FAIL n5_cnt: got %0d expected 1", cnt5); end
    n_chk++; if (errc != 0) begin n_fail++; $display("FAIL n5_err: got %0d expected 0", errc); end
  endtask

  initial begin
    test_reset();
    test_no_b_latency();
    test_b_insert(0);
    test_back_to_back();
    test_b_insert(3);
    test_bypass();
    test_illegal();
    test_malformed();
    test_reset_midstream();
    test_param_n();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
